// File: rtl/fpu_issue.sv
// rtl/fpu_issue.sv - issue sequencer between a request/response port and a multi-cycle FPU
// Optional macro FPU_ISSUE_TIMEOUT_EN adds a WAIT watchdog that returns resp_err=1, resp_data=0.
module fpu_issue #(
    parameter int LOG_BIT = 5,
    parameter int EXP_BIT = 8,
    parameter int N_BIT   = 1 << LOG_BIT,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N_BIT-1:0] req_a,
    input  logic [N_BIT-1:0] req_b,
    input  logic [1:0]       req_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [N_BIT-1:0] resp_data,
    output logic             resp_err,
    output logic [N_BIT-1:0] fpu_a,
    output logic [N_BIT-1:0] fpu_b,
    output logic [1:0]       fpu_op,
    input  logic [N_BIT-1:0] fpu_out,
    input  logic             fpu_ready
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_RESP} state_t;

    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_IDLE = 2'b11;

    state_t           r_state;
    state_t           w_next;
    logic [N_BIT-1:0] r_a;
    logic [N_BIT-1:0] r_b;
    logic [N_BIT-1:0] r_data;
    logic [1:0]       r_op;
    logic             w_accept;
    logic             w_capture;
    logic             w_expire;

    // Format parameters describe the attached FPU; the sequencer never looks inside operands.
    logic w_unused_cfg;
    assign w_unused_cfg = (EXP_BIT >= N_BIT) | (TIMEOUT < 1);

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_capture  = 1'b0;
        w_expire   = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        fpu_op     = OP_IDLE;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_EXEC;
                end
            end
            S_EXEC: begin
                fpu_op = r_op;
                // fpu_ready may still be high from the previous multiply, so never trust it here.
                if (r_op == OP_MUL) begin
                    w_next = S_WAIT;
                end else begin
                    w_capture = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_WAIT: begin
                fpu_op = r_op;
                if (fpu_ready) begin
                    w_capture = 1'b1;
                    w_next    = S_RESP;
                end
`ifdef FPU_ISSUE_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_expire = 1'b1;
                    w_next   = S_RESP;
                end
`endif
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= OP_IDLE;
            r_data <= '0;
        end else begin
            if (w_accept) begin
                r_a  <= req_a;
                r_b  <= req_b;
                r_op <= req_op;
            end
            if (w_capture) begin
                r_data <= fpu_out;
            end else if (w_expire) begin
                r_data <= '0;
            end
        end
    end

`ifdef FPU_ISSUE_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_EXEC) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture) begin
                r_err <= 1'b0;
            end else if (w_expire) begin
                r_err <= 1'b1;
            end
        end
    end

    assign resp_err = r_err;
`else
    assign resp_err = 1'b0;
`endif

    assign resp_data = r_data;
    assign fpu_a     = r_a;
    assign fpu_b     = r_b;

endmodule

// File: tb/tb_fpu_issue.sv
// tb/tb_fpu_issue.sv - directed self-checking bench for fpu_issue
// Inputs change and outputs are sampled on the falling edge; the bench plays the FPU.
module tb_fpu_issue;

    localparam int N  = 32;
    localparam int TO = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic [1:0]   req_op;
    logic         resp_valid;
    logic         resp_ready;
    logic [N-1:0] resp_data;
    logic         resp_err;
    logic [N-1:0] fpu_a;
    logic [N-1:0] fpu_b;
    logic [1:0]   fpu_op;
    logic [N-1:0] fpu_out;
    logic         fpu_ready;

    int checks = 0;
    int errors = 0;

    fpu_issue #(.LOG_BIT(5), .EXP_BIT(8), .N_BIT(N), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .fpu_op     (fpu_op),
        .fpu_out    (fpu_out),
        .fpu_ready  (fpu_ready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Non-multiply op: accept, one EXEC cycle, response on the third sampled cycle.
    task automatic run_simple(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] op, input logic [31:0] res);
        check_val({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        fpu_out = res; resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF; req_op = ~op;
        check_val({tag, "_op"}, {30'd0, fpu_op}, {30'd0, op});
        check_val({tag, "_a"}, fpu_a, a);
        check_val({tag, "_b"}, fpu_b, b);
        check_val({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
        tick();
        check_val({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        check_val({tag, "_data"}, resp_data, res);
        check_val({tag, "_err"}, {31'd0, resp_err}, 32'd0);
        tick();
        check_val({tag, "_done"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = 2'b00;
        resp_ready = 1'b0; fpu_out = '0; fpu_ready = 1'b0;
        tick(); tick();
        check_val("rst_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_fop", {30'd0, fpu_op}, 32'd3);
        check_val("rst_valid", {31'd0, resp_valid}, 32'd0);
        check_val("rst_data", resp_data, 32'd0);
        check_val("rst_err", {31'd0, resp_err}, 32'd0);
        check_val("rst_a", fpu_a, 32'd0);
        rst = 1'b0;
        tick();

        run_simple("add", 32'h3F80_0000, 32'h4000_0000, 2'b01, 32'h4040_0000);
        run_simple("sub", 32'h4040_0000, 32'h3F80_0000, 2'b00, 32'h4000_0000);
        run_simple("abs", 32'hC049_0FDB, 32'h0000_0000, 2'b11, 32'h4049_0FDB);

        // Back-to-back multiplies, second one with a stale fpu_ready during EXEC.
        req_a = 32'h4000_0000; req_b = 32'h4040_0000; req_op = 2'b10; req_valid = 1'b1;
        fpu_ready = 1'b0; fpu_out = '0;
        tick();
        req_valid = 1'b0;
        check_val("mul1_exec_op", {30'd0, fpu_op}, 32'd2);
        tick();
        check_val("mul1_wait", {31'd0, resp_valid}, 32'd0);
        check_val("mul1_wait_op", {30'd0, fpu_op}, 32'd2);
        tick(); tick();
        check_val("mul1_wait2", {31'd0, resp_valid}, 32'd0);
        fpu_ready = 1'b1; fpu_out = 32'h40C0_0000;
        tick();
        check_val("mul1_valid", {31'd0, resp_valid}, 32'd1);
        check_val("mul1_data", resp_data, 32'h40C0_0000);
        fpu_out = 32'hDEAD_BEEF;
        tick();
        check_val("mul_gap_op", {30'd0, fpu_op}, 32'd3);
        req_a = 32'h3FC0_0000; req_b = 32'h3FC0_0000; req_op = 2'b10; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check_val("mul2_exec_op", {30'd0, fpu_op}, 32'd2);
        tick();
        check_val("mul2_stale", {31'd0, resp_valid}, 32'd0);
        fpu_ready = 1'b0;
        tick();
        check_val("mul2_wait", {31'd0, resp_valid}, 32'd0);
        fpu_ready = 1'b1; fpu_out = 32'h4010_0000;
        tick();
        check_val("mul2_valid", {31'd0, resp_valid}, 32'd1);
        check_val("mul2_data", resp_data, 32'h4010_0000);
        fpu_ready = 1'b0;
        tick();

        // Backpressure with a competing request held on the input.
        resp_ready = 1'b0;
        req_a = 32'h3F80_0000; req_b = 32'h3F80_0000; req_op = 2'b01; req_valid = 1'b1;
        fpu_out = 32'h4000_0000;
        tick();
        req_valid = 1'b0;
        tick();
        req_a = 32'h1234_5678; req_op = 2'b00; req_valid = 1'b1; fpu_out = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            check_val("bp_valid", {31'd0, resp_valid}, 32'd1);
            check_val("bp_data", resp_data, 32'h4000_0000);
            check_val("bp_ready", {31'd0, req_ready}, 32'd0);
            check_val("bp_a", fpu_a, 32'h3F80_0000);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        check_val("bp_release", {31'd0, resp_valid}, 32'd0);
        check_val("bp_idle", {31'd0, req_ready}, 32'd1);
        check_val("bp_noaccept", fpu_a, 32'h3F80_0000);
        req_valid = 1'b0;
        tick();

        // Reset while waiting on a multiply.
        req_a = 32'h4000_0000; req_b = 32'h4000_0000; req_op = 2'b10; req_valid = 1'b1;
        fpu_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        check_val("rw_wait", {31'd0, resp_valid}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rw_valid", {31'd0, resp_valid}, 32'd0);
        check_val("rw_fop", {30'd0, fpu_op}, 32'd3);
        check_val("rw_ready", {31'd0, req_ready}, 32'd1);
        check_val("rw_data", resp_data, 32'd0);
        check_val("rw_a", fpu_a, 32'd0);
        tick();
        run_simple("add2", 32'h3F80_0000, 32'h4000_0000, 2'b01, 32'h4040_0000);

`ifdef FPU_ISSUE_TIMEOUT_EN
        begin
            int waits;
            req_a = 32'h4000_0000; req_b = 32'h4040_0000; req_op = 2'b10; req_valid = 1'b1;
            fpu_ready = 1'b0; fpu_out = 32'h5555_5555; resp_ready = 1'b0;
            tick();
            req_valid = 1'b0;
            tick();
            waits = 0;
            while (!resp_valid && waits < TO + 10) begin
                waits++;
                tick();
            end
            check_val("to_cycles", waits, TO);
            check_val("to_valid", {31'd0, resp_valid}, 32'd1);
            check_val("to_data", resp_data, 32'd0);
            check_val("to_err", {31'd0, resp_err}, 32'd1);
            resp_ready = 1'b1;
            tick();
            run_simple("to_add", 32'h3F80_0000, 32'h4000_0000, 2'b01, 32'h4040_0000);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_issue.md
FPU_ISSUE -- requirements
Module: fpu_issue

Interface
REQ-001 SHALL have parameter LOG_BIT, default 5, log2 of the operand width.
REQ-002 SHALL have parameter EXP_BIT, default 8, exponent width.
REQ-003 SHALL have parameter N_BIT, default 1<<LOG_BIT, operand width.
REQ-004 SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles; used only under FPU_ISSUE_TIMEOUT_EN.
REQ-005 SHALL have one clock and an asynchronous, active-high reset; ports are clk and rst.
REQ-006 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-007 SHALL have ports: rst  in  1  asynchronous active-high reset.
REQ-008 SHALL have ports: req_valid  in  1; req_ready  out  1; request handshake.
REQ-009 SHALL have ports: req_a, req_b  in  N_BIT  operands; req_op  in  2  op (00 sub, 01 add, 10 mul, 11 abs(a)).
REQ-010 SHALL have ports: resp_valid  out  1; resp_ready  in  1; resp_data  out  N_BIT; resp_err  out  1.
REQ-011 SHALL have ports: fpu_a, fpu_b  out  N_BIT; fpu_op  out  2; fpu_out  in  N_BIT; fpu_ready  in  1.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, WAIT, RESP.
REQ-013 SHALL assert req_ready only in IDLE; on req_valid&req_ready, register a, b, op and go to EXEC.
REQ-014 SHALL drive fpu_op=11 in IDLE and RESP, and the registered op in EXEC and WAIT.
REQ-015 SHALL drive fpu_a/fpu_b from the operand registers at all times.
REQ-016 SHALL guarantee at least one cycle of fpu_op=11 between two issued ops, so every multiply presents an op change (start) to the FPU.
REQ-017 SHALL, for op 00/01/11, capture fpu_out at the end of EXEC and go to RESP; latency from accept to resp_valid is 2 cycles.
REQ-018 SHALL, for op 10, ignore fpu_ready in EXEC (it may be stale from the previous multiply) and go to WAIT.
REQ-019 SHALL, in WAIT, capture fpu_out in the first cycle fpu_ready=1 and go to RESP the next cycle.
REQ-020 SHALL hold resp_valid=1, resp_data and resp_err stable in RESP until resp_ready=1, then go to IDLE.
REQ-021 SHALL not accept a new request in the cycle the response handshake completes; minimum issue interval is 3 cycles.
REQ-022 SHALL ignore req_valid outside IDLE, and ignore req_a/req_b/req_op changes after acceptance.

Reset
REQ-023 SHALL, on rst=1 at any time including mid-WAIT, go to IDLE.
REQ-024 SHALL, on reset, clear resp_valid, resp_err, resp_data, the operand registers and the timeout counter.
REQ-025 SHALL, on reset, set req_ready=1 and fpu_op=11.

Configuration
REQ-026 SHALL, with FPU_ISSUE_TIMEOUT_EN defined, count WAIT cycles; on reaching TIMEOUT without fpu_ready, go to RESP with resp_data=0, resp_err=1.
REQ-027 SHALL, with FPU_ISSUE_TIMEOUT_EN defined, clear the counter on entering WAIT.
REQ-028 SHALL, without FPU_ISSUE_TIMEOUT_EN, have no counter, tie resp_err to 0, and wait in WAIT indefinitely.

Verification
REQ-029 SHALL test add: a=0x3F800000, b=0x40000000, op=01 -> resp_data=0x40400000 two cycles after accept, resp_err=0.
REQ-030 SHALL test sub and abs: a=0x40400000, b=0x3F800000, op=00 -> 0x40000000; then a=0xC0490FDB, op=11 -> 0x40490FDB.
REQ-031 SHALL test back-to-back multiplies: 2.0*3.0 -> 0x40C00000, then 1.5*1.5 -> 0x40100000.
REQ-032 SHALL, in the multiply test, see fpu_op=11 between the two multiplies, and SHALL ignore a stale fpu_ready=1 held in the second EXEC.
REQ-033 SHALL test backpressure: resp_ready low for 5 cycles -> resp_valid and resp_data stable, req_ready=0, and a pending req_valid is not accepted.
REQ-034 SHALL test reset mid-operation: rst pulsed in WAIT -> next cycle IDLE, resp_valid=0, fpu_op=11; a following add returns correctly.
REQ-035 SHALL test timeout (FPU_ISSUE_TIMEOUT_EN defined): multiply with fpu_ready held 0 -> resp_err=1, resp_data=0 after TIMEOUT WAIT cycles.
